// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
//
// Bridges the CPU's single-outstanding native memory port onto an AXI4-Lite
// master. One request is in flight at a time. Writes issue AW and W together
// and let them complete independently. Reads issue AR. The cycle count of each
// completed transaction is reported on last_latency.
//
// Ports
//   clk, rstn           : clock (posedge) and asynchronous active-low reset
//   mem_valid/mem_ready : CPU request handshake (mem_ready is a 1-cycle pulse)
//   mem_instr           : request is an instruction fetch (drives arprot[2])
//   mem_addr/wdata/wstrb: CPU request payload (wstrb == 0 means read)
//   mem_rdata           : read data, valid in the mem_ready cycle of a read
//   mem_axi_aw*/w*/b*   : AXI4-Lite write address / data / response channels
//   mem_axi_ar*/r*      : AXI4-Lite read address / data channels
//   last_latency        : saturating cycle count of the last finished request
module axi_lite_master_bridge #(
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_valid,
  input  logic             mem_instr,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_axi_awvalid,
  input  logic             mem_axi_awready,
  output logic [31:0]      mem_axi_awaddr,
  output logic [2:0]       mem_axi_awprot,
  output logic             mem_axi_wvalid,
  input  logic             mem_axi_wready,
  output logic [31:0]      mem_axi_wdata,
  output logic [3:0]       mem_axi_wstrb,
  input  logic             mem_axi_bvalid,
  output logic             mem_axi_bready,
  output logic             mem_axi_arvalid,
  input  logic             mem_axi_arready,
  output logic [31:0]      mem_axi_araddr,
  output logic [2:0]       mem_axi_arprot,
  input  logic             mem_axi_rvalid,
  output logic             mem_axi_rready,
  input  logic [31:0]      mem_axi_rdata,
  output logic [LAT_W-1:0] last_latency
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

  state_t state, state_nxt;

  logic aw_done, w_done;
  logic aw_done_nxt, w_done_nxt;
  logic awvalid_nxt, wvalid_nxt, arvalid_nxt;
  logic bready_nxt, rready_nxt, mem_ready_nxt;
  logic accept, finish;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [LAT_W-1:0] lat_cnt, lat_inc;

  assign aw_fire = mem_axi_awvalid && mem_axi_awready;
  assign w_fire  = mem_axi_wvalid  && mem_axi_wready;
  assign b_fire  = mem_axi_bvalid  && mem_axi_bready;
  assign ar_fire = mem_axi_arvalid && mem_axi_arready;
  assign r_fire  = mem_axi_rvalid  && mem_axi_rready;

  // Writes are always unprivileged, secure, data accesses.
  assign mem_axi_awprot = 3'b000;

  // Saturating increment; the completing edge reports this value so the
  // handshake cycle itself is included in the latency.
  assign lat_inc = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_bready  <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_ready       <= 1'b0;
    end else begin
      state           <= state_nxt;
      aw_done         <= aw_done_nxt;
      w_done          <= w_done_nxt;
      mem_axi_awvalid <= awvalid_nxt;
      mem_axi_wvalid  <= wvalid_nxt;
      mem_axi_arvalid <= arvalid_nxt;
      mem_axi_bready  <= bready_nxt;
      mem_axi_rready  <= rready_nxt;
      mem_ready       <= mem_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    awvalid_nxt   = mem_axi_awvalid;
    wvalid_nxt    = mem_axi_wvalid;
    arvalid_nxt   = mem_axi_arvalid;
    bready_nxt    = mem_axi_bready;
    rready_nxt    = mem_axi_rready;
    mem_ready_nxt = 1'b0;
    accept        = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        // !mem_ready stops the still-held request from being taken twice.
        if (mem_valid && !mem_ready) begin
          accept      = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (mem_wstrb != 4'b0000) begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end else begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W finish independently; either order or the same cycle.
        if (aw_fire) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_fire) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_fire) begin
          bready_nxt    = 1'b0;
          mem_ready_nxt = 1'b1;
          finish        = 1'b1;
          state_nxt     = IDLE;
        end
      end
      RD_REQ: begin
        if (ar_fire) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_fire) begin
          rready_nxt    = 1'b0;
          mem_ready_nxt = 1'b1;
          finish        = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request payload is captured only on accept, so the AXI outputs stay
  // stable while their valids are high regardless of what the CPU does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_axi_awaddr <= '0;
      mem_axi_wdata  <= '0;
      mem_axi_wstrb  <= '0;
      mem_axi_araddr <= '0;
      mem_axi_arprot <= '0;
      mem_rdata      <= '0;
      lat_cnt        <= '0;
      last_latency   <= '0;
    end else begin
      if (accept) begin
        mem_axi_awaddr <= mem_addr;
        mem_axi_wdata  <= mem_wdata;
        mem_axi_wstrb  <= mem_wstrb;
        mem_axi_araddr <= mem_addr;
        mem_axi_arprot <= {mem_instr, 2'b00};
        lat_cnt        <= '0;
      end else if (state != IDLE) begin
        lat_cnt <= lat_inc;
      end
      if (r_fire) begin
        mem_rdata <= mem_axi_rdata;
      end
      if (finish) begin
        last_latency <= lat_inc;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge
//
// Directed bench for axi_lite_master_bridge. A small AXI4-Lite slave model
// with configurable ready/response delays stands in for the memory. The
// default delays (1,1,1,1) reproduce axi_memory timing. The CPU side is
// driven by a linear sequence of requests, and each observation is an
// immediate assertion against a hand-computed value.
//
// Ports: none (top-level bench).
module tb_axi_lite_master_bridge;

  localparam int LAT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             mem_valid = 1'b0;
  logic             mem_instr = 1'b0;
  logic             mem_ready;
  logic [31:0]      mem_addr = '0;
  logic [31:0]      mem_wdata = '0;
  logic [3:0]       mem_wstrb = '0;
  logic [31:0]      mem_rdata;
  logic             mem_axi_awvalid, mem_axi_awready;
  logic [31:0]      mem_axi_awaddr;
  logic [2:0]       mem_axi_awprot;
  logic             mem_axi_wvalid, mem_axi_wready;
  logic [31:0]      mem_axi_wdata;
  logic [3:0]       mem_axi_wstrb;
  logic             mem_axi_bvalid, mem_axi_bready;
  logic             mem_axi_arvalid, mem_axi_arready;
  logic [31:0]      mem_axi_araddr;
  logic [2:0]       mem_axi_arprot;
  logic             mem_axi_rvalid, mem_axi_rready;
  logic [31:0]      mem_axi_rdata;
  logic [LAT_W-1:0] last_latency;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.LAT_W(LAT_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_valid       (mem_valid),
    .mem_instr       (mem_instr),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_rdata       (mem_rdata),
    .mem_axi_awvalid (mem_axi_awvalid),
    .mem_axi_awready (mem_axi_awready),
    .mem_axi_awaddr  (mem_axi_awaddr),
    .mem_axi_awprot  (mem_axi_awprot),
    .mem_axi_wvalid  (mem_axi_wvalid),
    .mem_axi_wready  (mem_axi_wready),
    .mem_axi_wdata   (mem_axi_wdata),
    .mem_axi_wstrb   (mem_axi_wstrb),
    .mem_axi_bvalid  (mem_axi_bvalid),
    .mem_axi_bready  (mem_axi_bready),
    .mem_axi_arvalid (mem_axi_arvalid),
    .mem_axi_arready (mem_axi_arready),
    .mem_axi_araddr  (mem_axi_araddr),
    .mem_axi_arprot  (mem_axi_arprot),
    .mem_axi_rvalid  (mem_axi_rvalid),
    .mem_axi_rready  (mem_axi_rready),
    .mem_axi_rdata   (mem_axi_rdata),
    .last_latency    (last_latency)
  );

  // Slave model configuration: ready delays count cycles of valid seen before
  // ready rises (0 = ready held high while idle); resp_lat counts cycles after
  // the request handshake before bvalid/rvalid (0 = same edge).
  int aw_lat = 1, w_lat = 1, ar_lat = 1, resp_lat = 1;
  int aw_cnt, w_cnt, ar_cnt, resp_cnt;
  int aw_count, ar_count;
  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_awprot, s_arprot;
  logic [31:0] mem [0:255];

  logic aw_fire, w_fire, ar_fire;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  assign aw_fire = mem_axi_awvalid && mem_axi_awready;
  assign w_fire  = mem_axi_wvalid && mem_axi_wready;
  assign ar_fire = mem_axi_arvalid && mem_axi_arready;
  assign wr_addr = aw_fire ? mem_axi_awaddr : s_awaddr;
  assign wr_data = w_fire ? mem_axi_wdata : s_wdata;
  assign wr_strb = w_fire ? mem_axi_wstrb : s_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] od, input logic [31:0] nd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = od;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = nd[b*8 +: 8];
    return r;
  endfunction

  // AXI4-Lite slave model; shares rstn with the bridge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_axi_awready <= 1'b0;
      mem_axi_wready  <= 1'b0;
      mem_axi_arready <= 1'b0;
      mem_axi_bvalid  <= 1'b0;
      mem_axi_rvalid  <= 1'b0;
      mem_axi_rdata   <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; resp_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0] <= 32'hCAFE_F00D;
    end else begin
      if (aw_fire) begin
        aw_got   <= 1'b1;
        s_awaddr <= mem_axi_awaddr;
        s_awprot <= mem_axi_awprot;
        aw_cnt   <= 0;
        aw_count <= aw_count + 1;
        mem_axi_awready <= (aw_lat == 0);
      end else if (mem_axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
        mem_axi_awready <= (aw_cnt + 1 >= aw_lat);
      end else begin
        mem_axi_awready <= (aw_lat == 0);
      end

      if (w_fire) begin
        w_got   <= 1'b1;
        s_wdata <= mem_axi_wdata;
        s_wstrb <= mem_axi_wstrb;
        w_cnt   <= 0;
        mem_axi_wready <= (w_lat == 0);
      end else if (mem_axi_wvalid) begin
        w_cnt <= w_cnt + 1;
        mem_axi_wready <= (w_cnt + 1 >= w_lat);
      end else begin
        mem_axi_wready <= (w_lat == 0);
      end

      if (ar_fire) begin
        s_araddr <= mem_axi_araddr;
        s_arprot <= mem_axi_arprot;
        ar_cnt   <= 0;
        ar_count <= ar_count + 1;
        r_pend   <= 1'b1;
        resp_cnt <= 0;
        mem_axi_arready <= (ar_lat == 0);
        if (resp_lat == 0) begin
          mem_axi_rvalid <= 1'b1;
          mem_axi_rdata  <= mem[mem_axi_araddr[9:2]];
        end
      end else if (mem_axi_arvalid) begin
        ar_cnt <= ar_cnt + 1;
        mem_axi_arready <= (ar_cnt + 1 >= ar_lat);
      end else begin
        mem_axi_arready <= (ar_lat == 0);
      end

      if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        mem[wr_addr[9:2]] <= merge(mem[wr_addr[9:2]], wr_data, wr_strb);
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        b_pend   <= 1'b1;
        resp_cnt <= 0;
        if (resp_lat == 0) mem_axi_bvalid <= 1'b1;
      end

      if (b_pend && !mem_axi_bvalid) begin
        resp_cnt <= resp_cnt + 1;
        if (resp_cnt + 1 >= resp_lat) mem_axi_bvalid <= 1'b1;
      end
      if (r_pend && !mem_axi_rvalid) begin
        resp_cnt <= resp_cnt + 1;
        if (resp_cnt + 1 >= resp_lat) begin
          mem_axi_rvalid <= 1'b1;
          mem_axi_rdata  <= mem[s_araddr[9:2]];
        end
      end
      if (mem_axi_bvalid && mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
        b_pend <= 1'b0;
      end
      if (mem_axi_rvalid && mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
        r_pend <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int ar_before;
  logic [31:0] got_rdata;
  logic hist_awvalid [64];
  logic hist_wvalid  [64];
  logic hist_arvalid [64];
  logic hist_bready  [64];
  logic hist_bvalid  [64];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one CPU request and waits for mem_ready. cyc ends as the cycle
  // number of the mem_ready pulse, counting the accept edge as cycle 0.
  // One extra edge is spent afterwards so the next request can be accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic instr,
                               input bit hold);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    mem_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      hist_awvalid[i] = 1'b0; hist_wvalid[i] = 1'b0; hist_arvalid[i] = 1'b0;
      hist_bready[i]  = 1'b0; hist_bvalid[i] = 1'b0;
    end
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      if (cyc < 64) begin
        hist_awvalid[cyc] = mem_axi_awvalid;
        hist_wvalid[cyc]  = mem_axi_wvalid;
        hist_arvalid[cyc] = mem_axi_arvalid;
        hist_bready[cyc]  = mem_axi_bready;
        hist_bvalid[cyc]  = mem_axi_bvalid;
      end
      if (mem_ready || cyc >= 80000) break;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("mem_ready_within_budget", mem_ready, 1'b1);
    got_rdata = mem_rdata;
    @(posedge clk); #1;
    if (!hold) mem_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_ready", mem_ready, 1'b0);
    checkOutput("reset_last_latency", last_latency, 16'h0);
    checkOutput("reset_awvalid", mem_axi_awvalid, 1'b0);
    checkOutput("reset_arvalid", mem_axi_arvalid, 1'b0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write 0x100 against memory timing");
    applyStimulus(32'h100, 32'hA5A5_1234, 4'b0101, 1'b0, 1'b0);
    checkOutput("wr_awvalid_c1", hist_awvalid[1], 1'b1);
    checkOutput("wr_wvalid_c1", hist_wvalid[1], 1'b1);
    checkOutput("wr_awaddr", s_awaddr, 32'h100);
    checkOutput("wr_wdata", s_wdata, 32'hA5A5_1234);
    checkOutput("wr_wstrb", s_wstrb, 4'b0101);
    checkOutput("wr_awprot", s_awprot, 3'b000);
    checkOutput("wr_ready_cycle", cyc, 5);
    checkOutput("wr_latency", last_latency, 16'd4);
    checkOutput("wr_ready_single_pulse", mem_ready, 1'b0);

    $display("[TB] read back 0x100");
    applyStimulus(32'h100, 32'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("rd_rdata_merged", got_rdata, 32'h00A5_0034);
    checkOutput("rd_ready_cycle", cyc, 5);
    checkOutput("rd_latency", last_latency, 16'd4);
    checkOutput("rd_arprot", s_arprot, 3'b000);
    checkOutput("rd_arvalid_c1", hist_arvalid[1], 1'b1);

    $display("[TB] instruction fetch of 0x0");
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
    checkOutput("fetch_arprot", s_arprot, 3'b100);
    checkOutput("fetch_rdata", got_rdata, 32'hCAFE_F00D);

    $display("[TB] minimum-latency write");
    aw_lat = 0; w_lat = 0; resp_lat = 0;
    @(posedge clk); #1;
    applyStimulus(32'h104, 32'h1122_3344, 4'b1111, 1'b0, 1'b0);
    checkOutput("min_ready_cycle", cyc, 3);
    checkOutput("min_latency", last_latency, 16'd2);

    $display("[TB] stub slave: awready early, wready at cycle 6");
    aw_lat = 0; w_lat = 5; resp_lat = 3;
    @(posedge clk); #1;
    applyStimulus(32'h108, 32'h5566_7788, 4'b0011, 1'b0, 1'b0);
    checkOutput("stub_awvalid_c1", hist_awvalid[1], 1'b1);
    checkOutput("stub_awvalid_c2", hist_awvalid[2], 1'b0);
    checkOutput("stub_wvalid_c6", hist_wvalid[6], 1'b1);
    checkOutput("stub_wvalid_c7", hist_wvalid[7], 1'b0);
    checkOutput("stub_bready_c6", hist_bready[6], 1'b0);
    checkOutput("stub_bready_c7", hist_bready[7], 1'b1);
    checkOutput("stub_bvalid_c9", hist_bvalid[9], 1'b0);
    checkOutput("stub_bvalid_c10", hist_bvalid[10], 1'b1);
    checkOutput("stub_ready_cycle", cyc, 11);
    checkOutput("stub_latency", last_latency, 16'd10);

    $display("[TB] mem_valid held across mem_ready, then new read");
    aw_lat = 1; w_lat = 1; ar_lat = 1; resp_lat = 1;
    @(posedge clk); #1;
    ar_before = ar_count;
    applyStimulus(32'h100, 32'h0, 4'b0000, 1'b0, 1'b1);
    checkOutput("hold_no_dup_arvalid", mem_axi_arvalid, 1'b0);
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("hold_second_arvalid_c1", hist_arvalid[1], 1'b1);
    checkOutput("hold_ar_count", ar_count - ar_before, 2);
    checkOutput("hold_second_rdata", got_rdata, 32'hCAFE_F00D);

    $display("[TB] long read response, latency saturation");
    resp_lat = 70000;
    @(posedge clk); #1;
    applyStimulus(32'h100, 32'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("long_latency_saturated", last_latency, 16'hFFFF);
    checkOutput("long_rdata", got_rdata, 32'h00A5_0034);
    resp_lat = 1;

    $display("[TB] reset during write response");
    resp_lat = 6;
    @(posedge clk); #1;
    mem_addr = 32'h200; mem_wdata = 32'h0BAD_BEEF; mem_wstrb = 4'b1111;
    mem_instr = 1'b0; mem_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!mem_axi_bready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rst_reached_wr_resp", mem_axi_bready, 1'b1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_bready", mem_axi_bready, 1'b0);
    checkOutput("rst_awvalid_wvalid", {mem_axi_awvalid, mem_axi_wvalid}, 2'b00);
    checkOutput("rst_arvalid_rready", {mem_axi_arvalid, mem_axi_rready}, 2'b00);
    checkOutput("rst_mem_ready", mem_ready, 1'b0);
    checkOutput("rst_last_latency", last_latency, 16'h0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
    checkOutput("rst_awaddr", mem_axi_awaddr, 32'h0);
    checkOutput("rst_wdata_wstrb", {mem_axi_wdata, mem_axi_wstrb}, 36'h0);
    checkOutput("rst_araddr_arprot", {mem_axi_araddr, mem_axi_arprot}, 35'h0);
    mem_valid = 1'b0;
    resp_lat = 1;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("post_rst_rdata", got_rdata, 32'hCAFE_F00D);
    checkOutput("post_rst_latency", last_latency, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
